// File: rtl/hilo_muldiv_seq_if.sv
// Pipeline-facing operation/result bundle for the HI/LO multiply/divide sequencer.
interface hilo_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             op_ready;
    logic             stall_out;
    logic             busy;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output op_valid, op_code, op_a, op_b, flush,
        input  op_ready, stall_out, busy, rd_data, rd_valid, hi_out, lo_out
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, flush,
        output op_ready, stall_out, busy, rd_data, rd_valid, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// Iterative HI/LO multiply (radix-2 shift-add) / restoring divide sequencer.
// Optional macro HILO_FAST_MULT_EN: single-cycle multiply straight into FIX.
module hilo_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    hilo_muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;
    localparam logic [2:0] OP_MFHI = 3'd6;
    localparam logic [2:0] OP_MFLO = 3'd7;

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic en);
        cneg_w = en ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        cneg_2w = en ? ({(2*WIDTH){1'b0}} - v) : v;
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;

    logic               op_ready_s;
    logic               accept_s;
    logic               is_mul_op_s;
    logic               is_div_op_s;
    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic               start_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_step_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] div_step_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;
    logic [2*WIDTH-1:0] mul_load_s;
    logic               fast_mul_s;

    assign op_ready_s  = (state_q == ST_IDLE);
    assign accept_s    = bus.op_valid & op_ready_s & ~bus.flush;
    assign is_mul_op_s = ~bus.op_code[2] & ~bus.op_code[1];
    assign is_div_op_s = ~bus.op_code[2] &  bus.op_code[1];
    // Codes 0 (MULT) and 2 (DIV) are the signed variants.
    assign sign_a_s    = ~bus.op_code[0] & bus.op_a[WIDTH-1];
    assign sign_b_s    = ~bus.op_code[0] & bus.op_b[WIDTH-1];
    assign abs_a_s     = cneg_w(bus.op_a, sign_a_s);
    assign abs_b_s     = cneg_w(bus.op_b, sign_b_s);
    assign start_s     = accept_s & (is_mul_op_s |
                         (is_div_op_s & (bus.op_b != {WIDTH{1'b0}})));

    // Shift-add step: add multiplicand into upper half when LSB set, then shift right with carry.
    assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_step_s  = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]}
                                  : {1'b0, acc_q[2*WIDTH-1:1]};
    // Restoring step: trial subtract on the shifted partial remainder; borrow means restore.
    assign div_trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_step_s  = div_trial_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                            : {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix_s  = cneg_2w(acc_q, neg_lo_q);
    assign fix_hi_s    = is_div_q ? cneg_w(acc_q[2*WIDTH-1:WIDTH], neg_hi_q)
                                  : prod_fix_s[2*WIDTH-1:WIDTH];
    assign fix_lo_s    = is_div_q ? cneg_w(acc_q[WIDTH-1:0], neg_lo_q)
                                  : prod_fix_s[WIDTH-1:0];

`ifdef HILO_FAST_MULT_EN
    assign mul_load_s  = {{WIDTH{1'b0}}, abs_a_s} * {{WIDTH{1'b0}}, abs_b_s};
    assign fast_mul_s  = 1'b1;
`else
    assign mul_load_s  = {{WIDTH{1'b0}}, abs_b_s};
    assign fast_mul_s  = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; flush aborts any in-flight op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = (is_mul_op_s & fast_mul_s) ? ST_FIX : ST_ITER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values per state.
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (bus.op_code)
                        OP_MTHI: hi_d = bus.op_a;
                        OP_MTLO: lo_d = bus.op_a;
                        OP_MFHI: begin
                            rd_data_d  = hi_q;
                            rd_valid_d = 1'b1;
                        end
                        OP_MFLO: begin
                            rd_data_d  = lo_q;
                            rd_valid_d = 1'b1;
                        end
                        default: begin
                            if (start_s) begin
                                cnt_d    = CW'(WIDTH - 1);
                                is_div_d = is_div_op_s;
                                neg_lo_d = sign_a_s ^ sign_b_s;
                                if (is_div_op_s) begin
                                    acc_d    = {{WIDTH{1'b0}}, abs_a_s};
                                    opnd_d   = abs_b_s;
                                    neg_hi_d = sign_a_s;
                                end else begin
                                    acc_d    = mul_load_s;
                                    opnd_d   = abs_a_s;
                                    neg_hi_d = sign_a_s ^ sign_b_s;
                                end
                            end else begin
                                cnt_d = cnt_q;
                            end
                        end
                    endcase
                end else begin
                    rd_valid_d = 1'b0;
                end
            end
            ST_ITER: begin
                if (!bus.flush) begin
                    acc_d = is_div_q ? div_step_s : mul_step_s;
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_FIX: begin
                if (!bus.flush) begin
                    hi_d = fix_hi_s;
                    lo_d = fix_lo_s;
                end else begin
                    hi_d = hi_q;
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            rd_data_q  <= {WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            acc_q      <= {(2*WIDTH){1'b0}};
            opnd_q     <= {WIDTH{1'b0}};
            cnt_q      <= {CW{1'b0}};
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
        end
    end

    assign bus.op_ready  = op_ready_s;
    assign bus.stall_out = bus.op_valid & ~op_ready_s;
    assign bus.busy      = busy_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;
endmodule
